// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared CPU types, defaults and fetch output field layout
package cpu_pkg;

  typedef enum logic [1:0] {
    ST_FETCH   = 2'd0,
    ST_DISCARD = 2'd1,
    ST_HALT    = 2'd2
  } fetch_state_e;

  localparam logic [15:0] RESET_PC_DEFAULT    = 16'h0000;
  localparam logic [3:0]  HALT_OPCODE_DEFAULT = 4'hF;

  localparam int OUT_PC_LSB    = 48;
  localparam int OUT_PC2_LSB   = 32;
  localparam int OUT_INSTR_LSB = 16;

  function automatic logic [63:0] pack_outputs(input logic [15:0] pc, input logic [15:0] instr);
    logic [63:0] o;
    o = '0;
    o[OUT_PC_LSB +: 16]    = pc;
    o[OUT_PC2_LSB +: 16]   = pc + 16'd2;
    o[OUT_INSTR_LSB +: 16] = instr;
    return o;
  endfunction

endpackage

// File: rtl/fetch_buffer.sv
// rtl/fetch_buffer.sv - one-entry instruction/pc holding register between fetch and IF/ID
module fetch_buffer (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic        drain,
  input  logic        clear,
  input  logic [15:0] load_pc,
  input  logic [15:0] load_instr,
  output logic        full,
  output logic [15:0] pc,
  output logic [15:0] instr
);

  logic        full_q, full_d;
  logic [15:0] pc_q, pc_d;
  logic [15:0] instr_q, instr_d;

  // Clear wins over load so a redirect drops same-cycle returning data.
  always_comb begin
    full_d  = full_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    if (clear) begin
      full_d = 1'b0;
    end else if (load) begin
      full_d  = 1'b1;
      pc_d    = load_pc;
      instr_d = load_instr;
    end else if (drain) begin
      full_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      full_q  <= 1'b0;
      pc_q    <= 16'h0000;
      instr_q <= 16'h0000;
    end else begin
      full_q  <= full_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
    end
  end

  assign full  = full_q;
  assign pc    = pc_q;
  assign instr = instr_q;

endmodule

// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - instruction fetch FSM with pc, redirect discard and halt handling
module fetch_stage
  import cpu_pkg::*;
#(
  parameter logic [15:0] RESET_PC    = RESET_PC_DEFAULT,
  parameter logic [3:0]  HALT_OPCODE = HALT_OPCODE_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall_in,
  input  logic        branch_taken,
  input  logic [15:0] branch_target,
  output logic        imem_req,
  output logic [15:0] imem_addr,
  input  logic        imem_ready,
  input  logic [15:0] imem_data,
  output logic [3:0]  opcode_out,
  output logic [63:0] outputs,
  output logic        fetch_stall_out,
  output logic        flush_out
);

  fetch_state_e state_q, state_d;
  logic [15:0]  pc_q, pc_d;
  logic [15:0]  tgt_q, tgt_d;
  logic         flush_q, flush_d;

  logic         buf_load;
  logic         buf_full;
  logic [15:0]  buf_pc;
  logic [15:0]  buf_instr;

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    tgt_d    = tgt_q;
    flush_d  = branch_taken;
    buf_load = 1'b0;
    imem_req = 1'b0;

    // A full buffer may still request when it drains this same cycle.
    case (state_q)
      ST_FETCH:   imem_req = ~buf_full | ~stall_in;
      ST_DISCARD: imem_req = 1'b1;
      default:    imem_req = 1'b0;
    endcase
    if (rst) imem_req = 1'b0;

    if (branch_taken) begin
      if (imem_req && !imem_ready) begin
        tgt_d   = branch_target;
        state_d = ST_DISCARD;
      end else begin
        pc_d    = branch_target;
        state_d = ST_FETCH;
      end
    end else begin
      case (state_q)
        ST_FETCH: begin
          if (imem_req && imem_ready) begin
            buf_load = 1'b1;
            pc_d     = pc_q + 16'd2;
            if (imem_data[15:12] == HALT_OPCODE) state_d = ST_HALT;
          end
        end
        ST_DISCARD: begin
          if (imem_ready) begin
            pc_d    = tgt_q;
            state_d = ST_FETCH;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_FETCH;
      pc_q    <= RESET_PC;
      tgt_q   <= 16'h0000;
      flush_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      tgt_q   <= tgt_d;
      flush_q <= flush_d;
    end
  end

  fetch_buffer u_buf (
    .clk        (clk),
    .rst        (rst),
    .load       (buf_load),
    .drain      (~stall_in),
    .clear      (branch_taken),
    .load_pc    (pc_q),
    .load_instr (imem_data),
    .full       (buf_full),
    .pc         (buf_pc),
    .instr      (buf_instr)
  );

  assign imem_addr       = pc_q;
  assign opcode_out      = buf_full ? buf_instr[15:12] : 4'h0;
  assign outputs         = buf_full ? pack_outputs(buf_pc, buf_instr) : 64'h0;
  assign fetch_stall_out = ~buf_full;
  assign flush_out       = flush_q;

endmodule

// File: tb/tb_fetch_stage.sv
// tb/tb_fetch_stage.sv - directed bench with cycle-level reference model for fetch_stage
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stall_in = 1'b0;
  logic        branch_taken = 1'b0;
  logic [15:0] branch_target = 16'h0000;
  logic        imem_ready = 1'b0;
  logic [15:0] imem_data;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic [3:0]  opcode_out;
  logic [63:0] outputs;
  logic        fetch_stall_out;
  logic        flush_out;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  fetch_stage dut (
    .clk             (clk),
    .rst             (rst),
    .stall_in        (stall_in),
    .branch_taken    (branch_taken),
    .branch_target   (branch_target),
    .imem_req        (imem_req),
    .imem_addr       (imem_addr),
    .imem_ready      (imem_ready),
    .imem_data       (imem_data),
    .opcode_out      (opcode_out),
    .outputs         (outputs),
    .fetch_stall_out (fetch_stall_out),
    .flush_out       (flush_out)
  );

  // Memory contents: address 0x0020 holds a halt, everything else a non-halt word.
  function automatic logic [15:0] mem_word(input logic [15:0] a);
    if (a == 16'h0020) return 16'hF000;
    return {1'b0, a[3:1], a[11:0]};
  endfunction

  assign imem_data = mem_word(imem_addr);

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [15:0] pc;
    logic [15:0] instr;
  } pres_t;

  pres_t m_buf[$];
  int    m_pc = 0;
  int    m_redirect = -1;
  bit    m_halted = 1'b0;
  bit    m_flush = 1'b0;

  always @(negedge clk) begin
    logic        exp_req;
    logic [63:0] exp_out;
    logic [3:0]  exp_op;
    logic [15:0] w;
    pres_t       e;
    int          p2;
    #2;
    if (rst) begin
      m_buf.delete();
      m_pc       = 0;
      m_redirect = -1;
      m_halted   = 1'b0;
      m_flush    = 1'b0;
    end
    exp_req = !rst && (m_redirect >= 0 || (!m_halted && (m_buf.size() == 0 || !stall_in)));
    exp_out = 64'h0;
    exp_op  = 4'h0;
    if (m_buf.size() != 0) begin
      p2      = (int'(m_buf[0].pc) + 2) % 65536;
      exp_out = {m_buf[0].pc, p2[15:0], m_buf[0].instr, 16'h0000};
      exp_op  = m_buf[0].instr[15:12];
    end
    check("m_imem_req", imem_req, exp_req);
    if (exp_req) check("m_imem_addr", imem_addr, m_pc[15:0]);
    check("m_flush_out", flush_out, m_flush);
    check("m_fetch_stall_out", fetch_stall_out, m_buf.size() == 0);
    check("m_opcode_out", opcode_out, exp_op);
    check("m_outputs", outputs, exp_out);

    if (!rst) begin
      if (branch_taken) begin
        m_buf.delete();
        m_halted = 1'b0;
        if (exp_req && !imem_ready) begin
          m_redirect = branch_target;
        end else begin
          m_pc       = branch_target;
          m_redirect = -1;
        end
      end else if (m_redirect >= 0) begin
        if (imem_ready) begin
          m_pc       = m_redirect;
          m_redirect = -1;
        end
      end else begin
        if (!stall_in && m_buf.size() != 0) void'(m_buf.pop_front());
        if (exp_req && imem_ready) begin
          w       = mem_word(m_pc[15:0]);
          e.pc    = m_pc[15:0];
          e.instr = w;
          m_buf.push_back(e);
          m_pc = (m_pc + 2) % 65536;
          if (w[15:12] == 4'hF) m_halted = 1'b1;
        end
      end
      m_flush = branch_taken;
    end
  end

  task automatic step(input logic rs, input logic s, input logic b, input logic [15:0] t, input logic r);
    @(negedge clk);
    rst           = rs;
    stall_in      = s;
    branch_taken  = b;
    branch_target = t;
    imem_ready    = r;
    #3;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    step(1, 0, 0, 16'h0, 1);
    check("rst_req", imem_req, 1'b0);
    check("rst_stall", fetch_stall_out, 1'b1);
    check("rst_outputs", outputs, 64'h0);
    step(1, 0, 0, 16'h0, 1);

    // streaming with memory ready every cycle
    step(0, 0, 0, 16'h0, 1);
    check("c0_req", imem_req, 1'b1);
    check("c0_addr", imem_addr, 16'h0000);
    step(0, 0, 0, 16'h0, 1);
    check("c1_addr", imem_addr, 16'h0002);
    check("c1_pc", outputs[63:48], 16'h0000);
    check("c1_stall", fetch_stall_out, 1'b0);
    // three-cycle wait on address 4
    step(0, 0, 0, 16'h0, 0);
    check("c2_addr", imem_addr, 16'h0004);
    check("c2_pc", outputs[63:48], 16'h0002);
    step(0, 0, 0, 16'h0, 0);
    check("w1_addr", imem_addr, 16'h0004);
    check("w1_stall", fetch_stall_out, 1'b1);
    step(0, 0, 0, 16'h0, 0);
    check("w2_addr", imem_addr, 16'h0004);
    step(0, 0, 0, 16'h0, 1);
    check("w3_stall", fetch_stall_out, 1'b1);
    step(0, 0, 0, 16'h0, 1);
    check("c6_pc", outputs[63:48], 16'h0004);
    check("c6_pc2", outputs[47:32], 16'h0006);
    check("c6_instr", outputs[31:16], 16'h2004);

    // downstream stall holds the presented instruction
    step(1'b0, 1, 0, 16'h0, 1);
    check("s0_req", imem_req, 1'b0);
    check("s0_op", opcode_out, 4'h3);
    step(0, 1, 0, 16'h0, 1);
    step(0, 1, 0, 16'h0, 1);
    step(0, 1, 0, 16'h0, 1);
    check("s3_pc", outputs[63:48], 16'h0006);
    check("s3_req", imem_req, 1'b0);
    check("s3_addr", imem_addr, 16'h0008);
    step(0, 0, 0, 16'h0, 1);
    check("s4_addr", imem_addr, 16'h0008);
    step(0, 0, 0, 16'h0, 1);
    check("s5_pc", outputs[63:48], 16'h0008);

    // redirect during an outstanding request
    step(0, 0, 1, 16'h0010, 1);
    step(0, 0, 0, 16'h0, 0);
    check("b0_flush", flush_out, 1'b1);
    check("b0_addr", imem_addr, 16'h0010);
    step(0, 0, 1, 16'h0100, 0);
    check("b1_flush", flush_out, 1'b0);
    step(0, 0, 0, 16'h0, 0);
    check("b2_flush", flush_out, 1'b1);
    check("b2_addr", imem_addr, 16'h0010);
    check("b2_req", imem_req, 1'b1);
    step(0, 0, 0, 16'h0, 1);
    check("b3_flush", flush_out, 1'b0);
    step(0, 0, 0, 16'h0, 1);
    check("b4_addr", imem_addr, 16'h0100);
    check("b4_stall", fetch_stall_out, 1'b1);
    step(0, 0, 0, 16'h0, 0);
    check("b5_pc", outputs[63:48], 16'h0100);

    // second redirect while discarding replaces the saved target
    step(0, 0, 1, 16'h0030, 0);
    step(0, 0, 1, 16'h0050, 0);
    step(0, 0, 0, 16'h0, 1);
    step(0, 0, 0, 16'h0, 1);
    check("d0_addr", imem_addr, 16'h0050);
    step(0, 0, 0, 16'h0, 0);
    check("d1_pc", outputs[63:48], 16'h0050);

    // halt opcode stops fetching until a redirect
    step(0, 0, 1, 16'h0020, 1);
    step(0, 0, 0, 16'h0, 1);
    check("h0_addr", imem_addr, 16'h0020);
    step(0, 0, 0, 16'h0, 1);
    check("h1_op", opcode_out, 4'hF);
    check("h1_instr", outputs[31:16], 16'hF000);
    check("h1_req", imem_req, 1'b0);
    step(0, 0, 0, 16'h0, 1);
    check("h2_stall", fetch_stall_out, 1'b1);
    step(0, 0, 0, 16'h0, 1);
    step(0, 0, 0, 16'h0, 1);
    check("h4_req", imem_req, 1'b0);
    step(0, 0, 1, 16'h0040, 0);
    step(0, 0, 0, 16'h0, 1);
    check("h6_flush", flush_out, 1'b1);
    check("h6_req", imem_req, 1'b1);
    check("h6_addr", imem_addr, 16'h0040);
    step(0, 0, 0, 16'h0, 0);
    check("h7_pc", outputs[63:48], 16'h0040);

    // pc wrap, then reset in the middle of a wait
    step(0, 0, 1, 16'hFFFE, 1);
    step(0, 0, 0, 16'h0, 1);
    check("x0_addr", imem_addr, 16'hFFFE);
    step(0, 0, 0, 16'h0, 0);
    check("x1_addr", imem_addr, 16'h0000);
    check("x1_pc", outputs[63:48], 16'hFFFE);
    check("x1_pc2", outputs[47:32], 16'h0000);
    step(1, 0, 0, 16'h0, 1);
    check("r0_outputs", outputs, 64'h0);
    check("r0_op", opcode_out, 4'h0);
    check("r0_req", imem_req, 1'b0);
    check("r0_stall", fetch_stall_out, 1'b1);
    step(0, 0, 0, 16'h0, 0);
    check("r1_req", imem_req, 1'b1);
    check("r1_addr", imem_addr, 16'h0000);
    step(0, 0, 0, 16'h0, 1);
    step(0, 0, 0, 16'h0, 0);
    check("r3_pc", outputs[63:48], 16'h0000);
    check("r3_instr", outputs[31:16], 16'h0000);

    @(negedge clk);
    #4;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 Parameter RESET_PC, 16'h0000, PC loaded on reset.
REQ-002 Parameter HALT_OPCODE, 4'hF, opcode that stops fetching.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 stall_in  input  1  downstream hazard stall; hold presented instruction, do not advance.
REQ-006 branch_taken  input  1  redirect request from execute, one-cycle pulse.
REQ-007 branch_target  input  16  redirect PC, valid with branch_taken.
REQ-008 imem_req  output  1  instruction memory request, level.
REQ-009 imem_addr  output  16  fetch address, stable while imem_req && !imem_ready.
REQ-010 imem_ready  input  1  imem_data valid this cycle; completes request.
REQ-011 imem_data  input  16  fetched instruction word.
REQ-012 opcode_out  output  4  instr[15:12] of presented instruction; 0 when none.
REQ-013 outputs  output  64  {pc[15:0], pc+2[15:0], instr[15:0], 16'h0000}; all-zero when none.
REQ-014 fetch_stall_out  output  1  high when no valid instruction presented (bubble into IF/ID register).
REQ-015 flush_out  output  1  one-cycle flush to IF/ID register on redirect.

Function
REQ-016 FSM states SHALL be FETCH, DISCARD, HALT.
REQ-017 FETCH: imem_req=1, imem_addr=pc; on imem_ready and no redirect, instruction SHALL be written into a 1-entry buffer (instr, pc) and pc SHALL become pc+2 (16-bit wrap, 16'hFFFE -> 16'h0000).
REQ-018 Buffer full SHALL block new requests (imem_req=0) until buffer drains; buffer drains on any cycle with stall_in=0.
REQ-019 Presented instruction = buffer contents while full; fetch_stall_out = ~full.
REQ-020 Latency: imem_ready in cycle N -> instruction presented in cycle N+1.
REQ-021 branch_taken (any state except during rst) SHALL empty buffer, assert flush_out next cycle for exactly one cycle, and take priority over stall_in.
REQ-022 branch_taken with no outstanding request or with imem_ready same cycle: returning data dropped, pc <= branch_target, state FETCH.
REQ-023 branch_taken while imem_req && !imem_ready: target SHALL be saved, state -> DISCARD; imem_addr stays unchanged; on imem_ready data dropped, pc <= saved target, state -> FETCH.
REQ-024 Second branch_taken during DISCARD SHALL overwrite saved target.
REQ-025 Accepted instruction with opcode HALT_OPCODE SHALL be presented normally, then state -> HALT: imem_req=0, pc held; only branch_taken or rst leaves HALT.
REQ-026 imem_req SHALL never deassert while a request is outstanding and unanswered.

Reset
REQ-027 rst asserted SHALL immediately force: pc=RESET_PC, state FETCH, buffer empty, saved target 0, imem_req=0, flush_out=0, opcode_out=0, outputs=0, fetch_stall_out=1.
REQ-028 First request SHALL issue in the first cycle after rst deasserts; rst mid-request abandons it (late imem_ready ignored until new request).

Structure
REQ-029 State encoding, RESET_PC default, HALT_OPCODE and output field offsets SHALL live in the shared cpu package.
REQ-030 The 1-entry buffer SHALL be a sub-module fetch_buffer (load, drain, clear, full, data); FSM and PC remain in fetch_stage.

Verification
REQ-031 Reset release, memory ready every cycle -> imem_addr 0,2,4,...; outputs[63:48] follow one cycle later; fetch_stall_out=0 from cycle 2.
REQ-032 imem_ready delayed 3 cycles for addr 16'h0004 -> imem_addr held 16'h0004, fetch_stall_out=1 for those cycles, then instruction at pc 4 presented.
REQ-033 stall_in high 4 cycles with buffer full -> same opcode_out/outputs held, imem_req=0, no pc advance; resumes at next pc.
REQ-034 branch_taken to 16'h0100 during outstanding request at 16'h0010 -> DISCARD, data for 0x0010 never presented, flush_out one cycle, next imem_addr 16'h0100.
REQ-035 Fetch 16'hF000 at pc 16'h0020 -> presented once, then imem_req=0 indefinitely; branch_taken to 16'h0040 resumes fetch at 16'h0040.
REQ-036 pc=16'hFFFE fetched -> next imem_addr 16'h0000; rst asserted mid-wait -> outputs zero immediately, refetch at RESET_PC.
